// File: rtl/div_unit_if.sv
// Operand/result bundle between the EX stage and the multi-cycle divider.
// start_i is a level request accepted when the divider can take it; busy_o stalls the pipeline meanwhile; ready_o pulses once when results update.
interface div_unit_if;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input  busy_o, ready_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, dividend_i, divisor_i,
    output busy_o, ready_o, quotient_o, remainder_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 32-bit divider (DIV/DIVU): quotient to LO, remainder to HI.
// One quotient bit per cycle; divide-by-zero finishes in a single cycle.
module div_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  div_unit_if.slave  div,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] quo_q, dvs_q, rem_q;
  logic [5:0]  cnt_q;
  logic        neg_q_q, neg_r_q;

  logic        accept, div_zero, last_iter;
  logic [31:0] dvd_abs, dvs_abs;
  logic [31:0] rem_shift, rem_sub, rem_next, quo_next;
  logic [31:0] q_fin, r_fin;
  logic        q_bit;

  // Operand setup and one restoring step; rem_q[31] acts as the 33rd
  // partial-remainder bit so the compare never overflows.
  always_comb begin
    accept    = div.start_i & ~div.annul_i & ((state_q == IDLE) | (state_q == DONE));
    div_zero  = (div.divisor_i == 32'd0);
    last_iter = (cnt_q == 6'd31);
    dvd_abs   = (div.signed_i & div.dividend_i[31]) ? (32'd0 - div.dividend_i) : div.dividend_i;
    dvs_abs   = (div.signed_i & div.divisor_i[31])  ? (32'd0 - div.divisor_i)  : div.divisor_i;
    rem_shift = {rem_q[30:0], quo_q[31]};
    q_bit     = rem_q[31] | (rem_shift >= dvs_q);
    rem_sub   = rem_shift - dvs_q;
    rem_next  = q_bit ? rem_sub : rem_shift;
    quo_next  = {quo_q[30:0], q_bit};
    q_fin     = neg_q_q ? (32'd0 - quo_next) : quo_next;
    r_fin     = neg_r_q ? (32'd0 - rem_next) : rem_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    div.busy_o = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = div_zero ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = accept ? (div_zero ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
    if (div.annul_i) state_d = IDLE;
    div.busy_o = rst_i & ((accept & ~div_zero) | ((state_q == CALC) & ~div.annul_i));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      quo_q           <= 32'd0;
      dvs_q           <= 32'd0;
      rem_q           <= 32'd0;
      cnt_q           <= 6'd0;
      neg_q_q         <= 1'b0;
      neg_r_q         <= 1'b0;
      div.ready_o     <= 1'b0;
      div.quotient_o  <= 32'd0;
      div.remainder_o <= 32'd0;
    end else begin
      div.ready_o <= 1'b0;
      if (accept) begin
        quo_q   <= dvd_abs;
        dvs_q   <= dvs_abs;
        rem_q   <= 32'd0;
        cnt_q   <= 6'd0;
        neg_q_q <= div.signed_i & (div.dividend_i[31] ^ div.divisor_i[31]);
        neg_r_q <= div.signed_i & div.dividend_i[31];
        if (div_zero) begin
          div.ready_o     <= 1'b1;
          div.quotient_o  <= 32'hFFFF_FFFF;
          div.remainder_o <= div.dividend_i;
        end
      end else if ((state_q == CALC) && !div.annul_i) begin
        quo_q <= quo_next;
        rem_q <= rem_next;
        cnt_q <= cnt_q + 6'd1;
        if (last_iter) begin
          div.ready_o     <= 1'b1;
          div.quotient_o  <= q_fin;
          div.remainder_o <= r_fin;
        end
      end
    end
  end

  assign state_o = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, back-to-back and mid-operation reset.
module tb_div_unit;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  div_unit_if dif ();

  div_unit dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .div     (dif),
    .state_o (state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and follows it to its ready pulse; lat counts cycles
  // from the request cycle, busy_ok records whether busy_o matched the stall rule.
  task automatic div_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output logic busy_ok);
    busy_ok = 1'b1;
    lat     = -1;
    tick();
    dif.start_i    = 1'b1;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    dif.signed_i   = sgn;
    @(negedge clk);
    if (dif.busy_o !== (b != 32'd0)) busy_ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        dif.start_i    = 1'b0;
        dif.dividend_i = $urandom;
        dif.divisor_i  = $urandom;
      end
      @(negedge clk);
      if (dif.ready_o === 1'b1) begin
        lat = c;
        if (dif.busy_o !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (dif.busy_o !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    dif.start_i    = 1'b1;
    dif.divisor_i  = 32'd5;
    dif.dividend_i = 32'd99;
    tick();
    tick();
    @(negedge clk);
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dif.busy_o); end
    checks++; if (dif.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", dif.ready_o); end
    checks++; if (dif.quotient_o !== 32'd0) begin errors++; $display("FAIL reset_q: got %h expected 0", dif.quotient_o); end
    checks++; if (dif.remainder_o !== 32'd0) begin errors++; $display("FAIL reset_r: got %h expected 0", dif.remainder_o); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    tick();
    dif.start_i = 1'b0;
    rst_n       = 1'b1;
  endtask

  task automatic test_unsigned();
    int   lat;
    logic ok;
    div_op(32'd100, 32'd7, 1'b0, lat, ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL divu_busy: got %b expected 1", ok); end
    checks++; if (dif.quotient_o !== 32'd14) begin errors++; $display("FAIL divu_q: got %h expected %h", dif.quotient_o, 32'd14); end
    checks++; if (dif.remainder_o !== 32'd2) begin errors++; $display("FAIL divu_r: got %h expected %h", dif.remainder_o, 32'd2); end
    tick();
    @(negedge clk);
    checks++; if (dif.ready_o !== 1'b0) begin errors++; $display("FAIL divu_pulse: got %b expected 0", dif.ready_o); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL divu_idle: got %0d expected 0", state_dbg); end
    checks++; if (dif.quotient_o !== 32'd14) begin errors++; $display("FAIL divu_hold: got %h expected %h", dif.quotient_o, 32'd14); end
  endtask

  task automatic test_signed();
    logic [31:0] va [2] = '{32'hFFFF_FFF9, 32'd7};
    logic [31:0] vb [2] = '{32'd2, 32'hFFFF_FFFE};
    logic [31:0] eq [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] er [2] = '{32'hFFFF_FFFF, 32'd1};
    int   lat;
    logic ok;
    for (int i = 0; i < 2; i++) begin
      div_op(va[i], vb[i], 1'b1, lat, ok);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
      checks++; if (dif.quotient_o !== eq[i]) begin errors++; $display("FAIL div_q[%0d]: got %h expected %h", i, dif.quotient_o, eq[i]); end
      checks++; if (dif.remainder_o !== er[i]) begin errors++; $display("FAIL div_r[%0d]: got %h expected %h", i, dif.remainder_o, er[i]); end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] va [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] vb [3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    logic        vs [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] eq [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] er [3] = '{32'd0, 32'd0, 32'd5};
    int   lat;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      div_op(va[i], vb[i], vs[i], lat, ok);
      checks++; if (lat !== 33) begin errors++; $display("FAIL ext_latency[%0d]: got %0d expected 33", i, lat); end
      checks++; if (dif.quotient_o !== eq[i]) begin errors++; $display("FAIL ext_q[%0d]: got %h expected %h", i, dif.quotient_o, eq[i]); end
      checks++; if (dif.remainder_o !== er[i]) begin errors++; $display("FAIL ext_r[%0d]: got %h expected %h", i, dif.remainder_o, er[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] va [2] = '{32'h0000_1234, 32'hFFFF_FF00};
    logic        vs [2] = '{1'b0, 1'b1};
    int   lat;
    logic ok;
    for (int i = 0; i < 2; i++) begin
      div_op(va[i], 32'd0, vs[i], lat, ok);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dz_busy[%0d]: got %b expected 1", i, ok); end
      checks++; if (dif.quotient_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q[%0d]: got %h expected ffffffff", i, dif.quotient_o); end
      checks++; if (dif.remainder_o !== va[i]) begin errors++; $display("FAIL dz_r[%0d]: got %h expected %h", i, dif.remainder_o, va[i]); end
    end
  endtask

  task automatic test_annul();
    int   lat;
    logic ok;
    logic bad;
    div_op(32'd100, 32'd7, 1'b0, lat, ok);
    tick();
    dif.start_i    = 1'b1;
    dif.dividend_i = 32'd50;
    dif.divisor_i  = 32'd3;
    dif.signed_i   = 1'b0;
    bad = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) dif.start_i = 1'b0;
      if (c == 10) dif.annul_i = 1'b1;
      @(negedge clk);
      if (dif.ready_o !== 1'b0) bad = 1'b1;
      if (c < 10 && dif.busy_o !== 1'b1) bad = 1'b1;
    end
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL annul_busy: got %b expected 0", dif.busy_o); end
    tick();
    dif.annul_i = 1'b0;
    @(negedge clk);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL annul_calc: got %b expected 0", bad); end
    checks++; if (dif.ready_o !== 1'b0) begin errors++; $display("FAIL annul_ready: got %b expected 0", dif.ready_o); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL annul_state: got %0d expected 0", state_dbg); end
    checks++; if (dif.quotient_o !== 32'd14) begin errors++; $display("FAIL annul_q: got %h expected %h", dif.quotient_o, 32'd14); end
    checks++; if (dif.remainder_o !== 32'd2) begin errors++; $display("FAIL annul_r: got %h expected %h", dif.remainder_o, 32'd2); end
    div_op(32'd50, 32'd3, 1'b0, lat, ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL annul_restart_latency: got %0d expected 33", lat); end
    checks++; if (dif.quotient_o !== 32'd16) begin errors++; $display("FAIL annul_restart_q: got %h expected %h", dif.quotient_o, 32'd16); end
    checks++; if (dif.remainder_o !== 32'd2) begin errors++; $display("FAIL annul_restart_r: got %h expected %h", dif.remainder_o, 32'd2); end
  endtask

  task automatic test_start_annul();
    logic [31:0] vb [2] = '{32'd0, 32'd3};
    for (int i = 0; i < 2; i++) begin
      tick();
      dif.start_i    = 1'b1;
      dif.annul_i    = 1'b1;
      dif.dividend_i = 32'd9;
      dif.divisor_i  = vb[i];
      @(negedge clk);
      checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL sa_busy[%0d]: got %b expected 0", i, dif.busy_o); end
      tick();
      dif.start_i = 1'b0;
      dif.annul_i = 1'b0;
      @(negedge clk);
      checks++; if (dif.ready_o !== 1'b0) begin errors++; $display("FAIL sa_ready[%0d]: got %b expected 0", i, dif.ready_o); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL sa_state[%0d]: got %0d expected 0", i, state_dbg); end
      checks++; if (dif.quotient_o !== 32'd16) begin errors++; $display("FAIL sa_q[%0d]: got %h expected %h", i, dif.quotient_o, 32'd16); end
    end
  endtask

  task automatic test_back_to_back();
    logic bad;
    tick();
    dif.start_i    = 1'b1;
    dif.signed_i   = 1'b0;
    dif.dividend_i = 32'd1000;
    dif.divisor_i  = 32'd10;
    bad = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      tick();
      if (c == 1) begin
        dif.dividend_i = 32'd77;
        dif.divisor_i  = 32'd5;
      end
      if (c == 66) begin
        dif.dividend_i = 32'h0000_ABCD;
        dif.divisor_i  = 32'd0;
      end
      if (c == 67) dif.start_i = 1'b0;
      @(negedge clk);
      if (c == 33) begin
        checks++; if (dif.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", dif.ready_o); end
        checks++; if (dif.quotient_o !== 32'd100) begin errors++; $display("FAIL b2b_q1: got %h expected %h", dif.quotient_o, 32'd100); end
        checks++; if (dif.remainder_o !== 32'd0) begin errors++; $display("FAIL b2b_r1: got %h expected 0", dif.remainder_o); end
        checks++; if (dif.busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy1: got %b expected 1", dif.busy_o); end
      end else if (c == 66) begin
        checks++; if (dif.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b expected 1", dif.ready_o); end
        checks++; if (dif.quotient_o !== 32'd15) begin errors++; $display("FAIL b2b_q2: got %h expected %h", dif.quotient_o, 32'd15); end
        checks++; if (dif.remainder_o !== 32'd2) begin errors++; $display("FAIL b2b_r2: got %h expected %h", dif.remainder_o, 32'd2); end
        checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy2: got %b expected 0", dif.busy_o); end
      end else if (c == 67) begin
        checks++; if (dif.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready3: got %b expected 1", dif.ready_o); end
        checks++; if (dif.quotient_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_q3: got %h expected ffffffff", dif.quotient_o); end
        checks++; if (dif.remainder_o !== 32'h0000_ABCD) begin errors++; $display("FAIL b2b_r3: got %h expected 0000abcd", dif.remainder_o); end
      end else if (c == 68) begin
        checks++; if (dif.ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready4: got %b expected 0", dif.ready_o); end
      end else begin
        if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b1) bad = 1'b1;
      end
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_calc: got %b expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    tick();
    dif.start_i    = 1'b1;
    dif.signed_i   = 1'b0;
    dif.dividend_i = 32'd100;
    dif.divisor_i  = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) dif.start_i = 1'b0;
      if (c == 5) rst_n = 1'b0;
    end
    @(negedge clk);
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy_in_reset: got %b expected 0", dif.busy_o); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dif.quotient_o !== 32'd0) begin errors++; $display("FAIL rmid_q: got %h expected 0", dif.quotient_o); end
    checks++; if (dif.remainder_o !== 32'd0) begin errors++; $display("FAIL rmid_r: got %h expected 0", dif.remainder_o); end
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", dif.busy_o); end
    checks++; if (dif.ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b expected 0", dif.ready_o); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d expected 0", state_dbg); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    dif.start_i    = 1'b0;
    dif.signed_i   = 1'b0;
    dif.annul_i    = 1'b0;
    dif.dividend_i = 32'd0;
    dif.divisor_i  = 32'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_div_zero();
    test_annul();
    test_start_annul();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
